// File: rtl/cmsdk_ahb_qos_req_regulator.sv
// Per-port request regulator for an AHB output-stage arbiter.
// Each input port gets a credit budget per window. Once a port's budget is spent,
// its request is masked, but only while some other port could use the bus.
// A granted port is never masked during a locked sequence.
module cmsdk_ahb_qos_req_regulator #(
  parameter int unsigned CREDIT_W = 6,
  parameter int unsigned WINDOW_W = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                req_port1,
  input  logic                req_port2,
  input  logic                req_port3,
  input  logic [1:0]          addr_in_port,
  input  logic                no_port,
  input  logic                HREADYM,
  input  logic [1:0]          HTRANSM,
  input  logic                HMASTLOCKM,
  input  logic                cfg_enable,
  input  logic [WINDOW_W-1:0] cfg_window,
  input  logic [CREDIT_W-1:0] cfg_credit1,
  input  logic [CREDIT_W-1:0] cfg_credit2,
  input  logic [CREDIT_W-1:0] cfg_credit3,
  output logic                req_out_port1,
  output logic                req_out_port2,
  output logic                req_out_port3,
  output logic [2:0]          throttled,
  output logic                window_tick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WINDOW_W-1:0] win_q, win_d;
  logic [CREDIT_W-1:0] cred_q [3];
  logic [CREDIT_W-1:0] cred_d [3];
  // Each window keeps its own copy of the credit limits. This means a mid-window
  // cfg_creditN edit cannot change the "unlimited" decision until the next reload.
  logic [CREDIT_W-1:0] lim_q  [3];
  logic [CREDIT_W-1:0] lim_d  [3];
  logic [CREDIT_W-1:0] cfg_cr [3];

  logic [2:0] req;
  logic [2:0] exh;
  logic [2:0] avail;
  logic [2:0] other_avail;
  logic       active;
  logic       accepted;
  logic       reload;

  // Decode the current beat and the window reload condition.
  always_comb begin
    req       = {req_port3, req_port2, req_port1};
    cfg_cr[0] = cfg_credit1;
    cfg_cr[1] = cfg_credit2;
    cfg_cr[2] = cfg_credit3;
    active    = (state_q != ST_IDLE);
    // NONSEQ (10) and SEQ (11) both have HTRANSM[1] set; IDLE and BUSY do not.
    accepted  = HREADYM && !no_port && HTRANSM[1];
    reload    = active && cfg_enable && (win_q == '0);
  end

  // Next-state logic for the FSM, the window counter and the credits.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    for (int unsigned i = 0; i < 3; i++) begin
      cred_d[i] = cred_q[i];
      lim_d[i]  = lim_q[i];
    end
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          state_d = ST_RUN;
          win_d   = cfg_window;
          for (int unsigned i = 0; i < 3; i++) begin
            cred_d[i] = cfg_cr[i];
            lim_d[i]  = cfg_cr[i];
          end
        end
      end
      ST_RUN, ST_LOCK: begin
        if (!cfg_enable) begin
          state_d = ST_IDLE;
        end else begin
          if (state_q == ST_RUN && HMASTLOCKM && !no_port) begin
            state_d = ST_LOCK;
          end else if (state_q == ST_LOCK && !HMASTLOCKM) begin
            state_d = ST_RUN;
          end
          if (reload) begin
            win_d = cfg_window;
            for (int unsigned i = 0; i < 3; i++) begin
              cred_d[i] = cfg_cr[i];
              lim_d[i]  = cfg_cr[i];
            end
          end else begin
            win_d = win_q - WINDOW_W'(1);
            for (int unsigned i = 0; i < 3; i++) begin
              if (accepted && addr_in_port == 2'(i + 1) && cred_q[i] != '0) begin
                cred_d[i] = cred_q[i] - CREDIT_W'(1);
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Work-conserving mask: an exhausted port is masked only when another port can use the bus.
  always_comb begin
    throttled = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      exh[i]   = (lim_q[i] != '0) && (cred_q[i] == '0);
      avail[i] = req[i] && !exh[i];
    end
    other_avail[0] = avail[1] | avail[2];
    other_avail[1] = avail[0] | avail[2];
    other_avail[2] = avail[0] | avail[1];
    if (active) begin
      for (int unsigned i = 0; i < 3; i++) begin
        throttled[i] = exh[i] && other_avail[i];
        if (state_q == ST_LOCK && addr_in_port == 2'(i + 1)) begin
          throttled[i] = 1'b0;
        end
      end
    end
    window_tick   = reload;
    req_out_port1 = req_port1 && !throttled[0];
    req_out_port2 = req_port2 && !throttled[1];
    req_out_port3 = req_port3 && !throttled[2];
  end

  // State, window and credit registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cred_q[i] <= '0;
        lim_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      for (int unsigned i = 0; i < 3; i++) begin
        cred_q[i] <= cred_d[i];
        lim_q[i]  <= lim_d[i];
      end
    end
  end

endmodule
